vga_fb_writer: RTL

CPU-side write engine for the VGA frame buffer. It sits between the io register bus (valid/addr/wdata/wstrb/rdata) and the write port (port A) of the VGA dual-port frame-buffer BRAM, replacing the tied-off write port. It provides an auto-incrementing pixel pointer for single-pixel writes and a hardware fill engine that writes one pixel per clock for bulk clears and solid spans.

---
 rtl/vga_fb_writer_if.sv | 25 ++
 rtl/vga_fb_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_writer_if.sv
// Register-bus bundle between the io decoder and the frame-buffer write engine.
// A read is a transaction with wstrb low; rdata is returned by the slave.
interface vga_fb_writer_if;
    logic        valid;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        wstrb;
    logic [31:0] rdata;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output rdata
    );
endinterface

// File: rtl/vga_fb_writer.sv
// CPU-side write engine for the VGA frame-buffer BRAM port A: auto-incrementing
// pixel pointer for single writes plus a one-pixel-per-clock fill engine.
module vga_fb_writer #(
    parameter int unsigned FB_SIZE = 49152,
    parameter int unsigned AW      = 16
) (
    input  logic           clk,
    input  logic           resetn,
    vga_fb_writer_if.slave bus,
    output logic           fb_we,
    output logic [AW-1:0]  fb_addr,
    output logic [7:0]     fb_wdata,
    output logic           busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;
    localparam int unsigned CW = 8;

    localparam logic [2:0] REG_PTR    = 3'd0;
    localparam logic [2:0] REG_DATA   = 3'd1;
    localparam logic [2:0] REG_FILL   = 3'd2;
    localparam logic [2:0] REG_COLOR  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam logic [AW-1:0] PTR_LAST = AW'(FB_SIZE - 1);

    logic [0:0]    state_q,     state_d;
    logic          valid_dly_q, valid_dly_d;
    logic [AW-1:0] ptr_q,       ptr_d;
    logic [CW-1:0] color_q,     color_d;
    logic [LW-1:0] remaining_q, remaining_d;
    logic          dropped_q,   dropped_d;
    logic [DW-1:0] rdata_q,     rdata_d;
    logic          fb_we_q,     fb_we_d;
    logic [AW-1:0] fb_addr_q,   fb_addr_d;
    logic [CW-1:0] fb_wdata_q,  fb_wdata_d;
    logic          busy_q,      busy_d;

    logic          cmd_c;
    logic          wr_c;
    logic          rd_c;
    logic          reg_wr_c;
    logic [LW-1:0] len_c;
    logic          unused_c;

    // Pointers at or beyond the last pixel (including out-of-range writes) wrap to 0.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p >= PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    // One command per transaction: rising edge of valid.
    always_comb begin
        cmd_c    = bus.valid & ~valid_dly_q;
        wr_c     = cmd_c & bus.wstrb;
        rd_c     = cmd_c & ~bus.wstrb;
        reg_wr_c = wr_c & (bus.addr <= REG_COLOR);
        len_c    = bus.wdata[LW-1:0];
        unused_c = ^bus.wdata[DW-1:LW];
    end

    always_comb begin
        state_d     = state_q;
        valid_dly_d = bus.valid;
        ptr_d       = ptr_q;
        color_d     = color_q;
        remaining_d = remaining_q;
        dropped_d   = dropped_q;
        rdata_d     = rdata_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_wdata_d  = fb_wdata_q;
        busy_d      = 1'b0;

        // Reads are serviced regardless of fill activity.
        if (rd_c) begin
            case (bus.addr)
                REG_PTR:    rdata_d = DW'(ptr_q);
                REG_FILL:   rdata_d = DW'(remaining_q);
                REG_COLOR:  rdata_d = DW'(color_q);
                REG_STATUS: begin
                    rdata_d   = {30'd0, dropped_q, busy_q};
                    dropped_d = 1'b0;
                end
                default:    rdata_d = '0;
            endcase
        end

        if (reg_wr_c && busy_q) begin
            dropped_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // busy_q can still be high on the last fill pixel; writes then drop.
                if (wr_c && !busy_q) begin
                    case (bus.addr)
                        REG_PTR: begin
                            ptr_d = bus.wdata[AW-1:0];
                        end
                        REG_DATA: begin
                            fb_we_d    = 1'b1;
                            fb_addr_d  = ptr_q;
                            fb_wdata_d = bus.wdata[CW-1:0];
                            ptr_d      = ptr_inc(ptr_q);
                        end
                        REG_FILL: begin
                            if (len_c != '0) begin
                                fb_we_d     = 1'b1;
                                busy_d      = 1'b1;
                                fb_addr_d   = ptr_q;
                                fb_wdata_d  = color_q;
                                ptr_d       = ptr_inc(ptr_q);
                                remaining_d = len_c - LW'(1);
                                state_d     = (len_c == LW'(1)) ? ST_IDLE : ST_FILL;
                            end
                        end
                        REG_COLOR: begin
                            color_d = bus.wdata[CW-1:0];
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_FILL: begin
                fb_we_d     = 1'b1;
                busy_d      = 1'b1;
                fb_addr_d   = ptr_q;
                fb_wdata_d  = color_q;
                ptr_d       = ptr_inc(ptr_q);
                remaining_d = remaining_q - LW'(1);
                if (remaining_q == LW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            valid_dly_q <= 1'b0;
            ptr_q       <= '0;
            color_q     <= '0;
            remaining_q <= '0;
            dropped_q   <= 1'b0;
            rdata_q     <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_wdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_dly_q <= valid_dly_d;
            ptr_q       <= ptr_d;
            color_q     <= color_d;
            remaining_q <= remaining_d;
            dropped_q   <= dropped_d;
            rdata_q     <= rdata_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_wdata_q  <= fb_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_wdata  = fb_wdata_q;
    assign busy      = busy_q;

endmodule
